ysyx_210457_bus_arbiter_n: RTL and testbench
============================================

Name: ysyx_210457_bus_arbiter_n

Overview:
Parametrised N-master arbiter in front of the single AXI bridge request/response port. Generalises the two-master (IF/MEM) arbiter:
- any number of masters;
- registered grant held across a whole transaction;
- one-outstanding handshake FSM;
- per-master flush that drops a stale response;
- ID-routed responses.

Sits between the core's fetch/LSU (and later DMA/cache refill) masters and the AXI bridge.

Parameters:
NUM_M, 2, number of masters; index 0 has highest fixed priority (LSU by convention)
ADDR_W, 32, address width
DATA_W, 64, data width
ID_W, 4, bus ID width; must satisfy 2**ID_W >= NUM_M

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
m_valid  in  NUM_M  per-master request valid
m_write  in  NUM_M  1=store, 0=load/fetch
m_addr  in  NUM_M*ADDR_W  packed request addresses
m_wdata  in  NUM_M*DATA_W  packed store data
m_size  in  NUM_M*2  packed access size (0=B,1=H,2=W,3=D)
m_flush  in  NUM_M  per-master flush; cancels that master's pending/in-flight access
m_ready  out  NUM_M  one-hot request accepted this cycle
m_rvalid  out  NUM_M  one-hot response valid
m_rdata  out  DATA_W  response data, shared, qualified by m_rvalid
bus_valid  out  1  request to bridge
bus_ready  in  1  bridge accepts request
bus_addr  out  ADDR_W  request address
bus_wdata  out  DATA_W  store data
bus_write  out  1  direction
bus_size  out  2  size
bus_id  out  ID_W  granted master index, zero-extended
bus_rvalid  in  1  bridge response valid (read data or write ack)
bus_rid  in  ID_W  response ID
bus_rdata  in  DATA_W  response data
busy  out  1  FSM not IDLE (stall source for pipeline control)

Behaviour:
- Reset: FSM=IDLE; grant=0; drop=0. All outputs 0: m_ready, m_rvalid, m_rdata, bus_*, busy.
- FSM IDLE:
  - If any m_valid & ~m_flush: latch winner index into grant, latch its addr/wdata/write/size into request registers, go ISSUE.
  - Winner is the lowest set index by default (see optional feature).
- FSM ISSUE:
  - bus_valid=1, bus_* driven from registers (registered outputs, stable until bus_ready).
  - On bus_ready: m_ready[grant]=1 for exactly that cycle, go WAIT.
  - If m_flush[grant] before bus_ready: withdraw (bus_valid drops next cycle), return IDLE, no m_ready.
- FSM WAIT:
  - On bus_rvalid & bus_rid==grant: m_rvalid[grant]=1 and m_rdata=bus_rdata, combinational same cycle, unless drop=1. Then go IDLE.
  - bus_rvalid with mismatched ID: ignored, stay WAIT.
- Flush in WAIT: m_flush[grant] sets drop. The response is still consumed from the bridge but not forwarded. drop clears on IDLE entry.
- Latency: request seen in IDLE -> bus_valid next cycle. Min request-to-response is 3 cycles (IDLE, ISSUE with bus_ready, WAIT with rvalid).
- Next grant is decided in IDLE only; no back-to-back without the IDLE cycle.
- busy = (state != IDLE).
- Simultaneous flush and response in WAIT: response dropped.
- Flush on a non-granted master: no effect on the FSM. That master's m_valid is masked in the same cycle.
- Reset mid-transaction: FSM to IDLE immediately. The bridge is reset by the same reset.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin. A last-grant pointer (reset 0) makes the search start at (last+1) mod NUM_M; pointer updates on each IDLE->ISSUE.
- Undefined: fixed priority, lowest index wins; no pointer register.

Decomposition:
- Shared defines package: size encodings (SIZE_B/H/W/D), FSM state encodings (ARB_IDLE/ISSUE/WAIT), ZERO_ADDR/ZERO_WORD.
- One sub-module: ysyx_210457_arb_pick, combinational priority/rotating picker. Inputs: request vector and start pointer. Outputs: one-hot grant and index.

Test Plan:
- NUM_M=2, m_valid=2'b11, bus_ready=1 next cycle, rvalid id=0 data=64'hDEAD_BEEF_0000_0001 -> master0 served first: m_ready[0] in ISSUE, m_rvalid[0] with that data; then master1 granted, bus_id=1.
- Master1 load addr 32'h8000_0010 size=3, bus_ready held low 5 cycles -> bus_valid/addr stable all 5 cycles; m_ready[1] pulses exactly once.
- Master1 in WAIT, m_flush[1] pulse, then rvalid id=1 -> m_rvalid stays 0; FSM returns IDLE; busy falls the following cycle.
- WAIT with grant=0, bus_rvalid id=1 -> ignored. Then id=0 -> m_rvalid[0]=1.
- ARB_ROUND_ROBIN_EN, NUM_M=3, all m_valid held high -> grant sequence 0,1,2,0. Without the macro: 0,0,0.
- reset asserted during WAIT -> next cycle all outputs 0, state IDLE. A later rvalid is ignored.

Source files
------------

// File: rtl/ysyx_210457_bus_arbiter_n_pkg.sv
// Shared encodings for the N-master bus arbiter.
// Access sizes, FSM states and zero constants.
package ysyx_210457_bus_arbiter_n_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    localparam logic [31:0] ZERO_ADDR = 32'h0;
    localparam logic [63:0] ZERO_WORD = 64'h0;

endpackage

// File: rtl/ysyx_210457_bus_arbiter_n_if.sv
// Master-side request/response bundle and bridge port.
// slave: arbiter view; master: environment view.
interface ysyx_210457_bus_arbiter_n_if #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic [NUM_M-1:0]        m_valid;
    logic [NUM_M-1:0]        m_write;
    logic [NUM_M*ADDR_W-1:0] m_addr;
    logic [NUM_M*DATA_W-1:0] m_wdata;
    logic [NUM_M*2-1:0]      m_size;
    logic [NUM_M-1:0]        m_flush;
    logic [NUM_M-1:0]        m_ready;
    logic [NUM_M-1:0]        m_rvalid;
    logic [DATA_W-1:0]       m_rdata;

    logic                    bus_valid;
    logic                    bus_ready;
    logic [ADDR_W-1:0]       bus_addr;
    logic [DATA_W-1:0]       bus_wdata;
    logic                    bus_write;
    logic [1:0]              bus_size;
    logic [ID_W-1:0]         bus_id;
    logic                    bus_rvalid;
    logic [ID_W-1:0]         bus_rid;
    logic [DATA_W-1:0]       bus_rdata;
    logic                    busy;

    modport slave (
        input  m_valid, m_write, m_addr, m_wdata, m_size, m_flush,
        output m_ready, m_rvalid, m_rdata,
        output bus_valid, bus_addr, bus_wdata, bus_write,
        output bus_size, bus_id,
        input  bus_ready, bus_rvalid, bus_rid, bus_rdata,
        output busy
    );

    modport master (
        output m_valid, m_write, m_addr, m_wdata, m_size, m_flush,
        input  m_ready, m_rvalid, m_rdata,
        input  bus_valid, bus_addr, bus_wdata, bus_write,
        input  bus_size, bus_id,
        output bus_ready, bus_rvalid, bus_rid, bus_rdata,
        input  busy
    );

endinterface

// File: rtl/ysyx_210457_arb_pick.sv
// Rotating priority picker: first set request at or after start.
// start=0 gives plain lowest-index-wins priority.
module ysyx_210457_arb_pick #(
    parameter int N  = 2,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] rot;
    logic [IW:0]    pos;

    // Rotate so the start position sits at bit 0, then scan upward.
    always_comb begin
        rot = {req, req} >> start;
        any = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                pos = {1'b0, start} + (IW+1)'(k);
                if (pos >= (IW+1)'(N))
                    pos = pos - (IW+1)'(N);
                idx = pos[IW-1:0];
            end
        end
    end

    // Decode the winning index back to a one-hot grant.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++)
            gnt[i] = any && (idx == IW'(i));
    end

endmodule

// File: rtl/ysyx_210457_bus_arbiter_n.sv
// N-master arbiter in front of the single AXI bridge port.
// Define ARB_ROUND_ROBIN_EN for rotating instead of fixed priority.
module ysyx_210457_bus_arbiter_n
    import ysyx_210457_bus_arbiter_n_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    ysyx_210457_bus_arbiter_n_if.slave  arb
);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;

    logic [NUM_M-1:0]  req;
    logic [NUM_M-1:0]  pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic [ID_W-1:0]   start;
    logic [NUM_M-1:0]  grant_oh;
    logic              flush_g;
    logic              fwd;
    logic [NUM_M-1:0]  ready;

    // A flushing master never competes in the same cycle.
    assign req = arb.m_valid & ~arb.m_flush;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_q;

    assign start = (last_q == ID_W'(NUM_M-1)) ? '0 : last_q + 1'b1;

    // Remember the last winner so the search starts just past it.
    always_ff @(posedge clock) begin
        if (reset)
            last_q <= '0;
        else if (state_q == ARB_IDLE && pick_any)
            last_q <= pick_idx;
    end
`else
    assign start = '0;
`endif

    ysyx_210457_arb_pick #(
        .N  (NUM_M),
        .IW (ID_W)
    ) u_pick (
        .req   (req),
        .start (start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // One-hot view of the held grant for flush and response routing.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_M; i++)
            grant_oh[i] = (grant_q == ID_W'(i));
    end

    assign flush_g = |(arb.m_flush & grant_oh);

    // Next-state, request capture and handshake outputs.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        drop_d  = drop_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        size_d  = size_q;
        ready   = '0;
        fwd     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                drop_d = 1'b0;
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ARB_ISSUE;
                    for (int i = 0; i < NUM_M; i++) begin
                        if (pick_gnt[i]) begin
                            addr_d  = arb.m_addr[i*ADDR_W +: ADDR_W];
                            wdata_d = arb.m_wdata[i*DATA_W +: DATA_W];
                            write_d = arb.m_write[i];
                            size_d  = arb.m_size[i*2 +: 2];
                        end
                    end
                end
            end
            ARB_ISSUE: begin
                if (arb.bus_ready) begin
                    // Bridge took it; a same-cycle flush only drops the reply.
                    state_d = ARB_WAIT;
                    if (flush_g)
                        drop_d = 1'b1;
                    else
                        ready = grant_oh;
                end else if (flush_g) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                if (flush_g)
                    drop_d = 1'b1;
                if (arb.bus_rvalid && arb.bus_rid == grant_q) begin
                    state_d = ARB_IDLE;
                    drop_d  = 1'b0;
                    fwd     = !drop_q && !flush_g;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and request registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            drop_q  <= 1'b0;
            addr_q  <= ADDR_W'(ZERO_ADDR);
            wdata_q <= DATA_W'(ZERO_WORD);
            write_q <= 1'b0;
            size_q  <= SIZE_B;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    assign arb.m_ready   = ready;
    assign arb.m_rvalid  = fwd ? grant_oh : '0;
    assign arb.m_rdata   = fwd ? arb.bus_rdata : DATA_W'(ZERO_WORD);
    assign arb.bus_valid = (state_q == ARB_ISSUE);
    assign arb.bus_addr  = addr_q;
    assign arb.bus_wdata = wdata_q;
    assign arb.bus_write = write_q;
    assign arb.bus_size  = size_q;
    assign arb.bus_id    = grant_q;
    assign arb.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ysyx_210457_bus_arbiter_n.sv
// Bench for ysyx_210457_bus_arbiter_n: directed scenarios, then random
// traffic checked every cycle against a transaction-level model.
module tb_ysyx_210457_bus_arbiter_n;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_210457_bus_arbiter_n_if #(
        .NUM_M(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
    ) arb_if ();

    ysyx_210457_bus_arbiter_n #(
        .NUM_M(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .arb   (arb_if)
    );

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model: at most one transaction, owned by one master.
    bit          t_on = 0, t_acc = 0, t_drop = 0;
    int          t_own = 0;
    int          last_g = 0;
    logic [AW-1:0] r_addr = '0;
    logic [DW-1:0] r_wdata = '0;
    logic          r_write = 1'b0;
    logic [1:0]    r_size = 2'd0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Compare all outputs against the model, then advance the model.
    task automatic check_and_step();
        bit fl, hit;
        logic [N-1:0] e_rdy, e_rv, elig;
        logic [DW-1:0] e_rd;
        int st, idx;
        fl  = arb_if.m_flush[t_own];
        hit = t_on && t_acc && arb_if.bus_rvalid &&
              (arb_if.bus_rid == IW'(t_own));
        e_rdy = (t_on && !t_acc && arb_if.bus_ready && !fl) ?
                N'(1) << t_own : '0;
        e_rv  = (hit && !t_drop && !fl) ? N'(1) << t_own : '0;
        e_rd  = (e_rv != 0) ? arb_if.bus_rdata : '0;
        if (check_en) begin
            chk("busy", arb_if.busy, t_on);
            chk("bus_valid", arb_if.bus_valid, t_on && !t_acc);
            chk("bus_addr", arb_if.bus_addr, r_addr);
            chk("bus_wdata", arb_if.bus_wdata, r_wdata);
            chk("bus_write", arb_if.bus_write, r_write);
            chk("bus_size", arb_if.bus_size, r_size);
            chk("bus_id", arb_if.bus_id, t_own);
            chk("m_ready", arb_if.m_ready, e_rdy);
            chk("m_rvalid", arb_if.m_rvalid, e_rv);
            chk("m_rdata", arb_if.m_rdata, e_rd);
        end
        if (reset) begin
            t_on = 0; t_acc = 0; t_drop = 0; t_own = 0; last_g = 0;
            r_addr = '0; r_wdata = '0; r_write = 0; r_size = 0;
        end else if (!t_on) begin
            elig = arb_if.m_valid & ~arb_if.m_flush;
            if (elig != 0) begin
                st = RR ? (last_g + 1) % N : 0;
                idx = -1;
                for (int k = 0; k < N; k++)
                    if (idx < 0 && elig[(st + k) % N]) idx = (st + k) % N;
                t_on = 1; t_acc = 0; t_drop = 0;
                t_own = idx; last_g = idx;
                r_addr  = arb_if.m_addr[idx*AW +: AW];
                r_wdata = arb_if.m_wdata[idx*DW +: DW];
                r_write = arb_if.m_write[idx];
                r_size  = arb_if.m_size[idx*2 +: 2];
            end
        end else if (!t_acc) begin
            if (arb_if.bus_ready) begin
                t_acc = 1; t_drop = fl;
            end else if (fl) begin
                t_on = 0;
            end
        end else begin
            if (fl) t_drop = 1;
            if (hit) begin t_on = 0; t_drop = 0; end
        end
    endtask

    always @(negedge clock) check_and_step();

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        arb_if.m_valid    = '0;
        arb_if.m_flush    = '0;
        arb_if.bus_ready  = 1'b0;
        arb_if.bus_rvalid = 1'b0;
        arb_if.bus_rid    = '0;
        arb_if.bus_rdata  = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic w, input logic [1:0] s,
                           input logic [DW-1:0] d);
        arb_if.m_addr[i*AW +: AW]  = a;
        arb_if.m_write[i]          = w;
        arb_if.m_size[i*2 +: 2]    = s;
        arb_if.m_wdata[i*DW +: DW] = d;
    endtask

    // Single master i: request, accept, respond; ends in IDLE.
    task automatic serve(input int i);
        arb_if.m_valid = N'(1) << i;
        cyc();
        arb_if.bus_ready = 1'b1;
        arb_if.m_valid = '0;
        cyc();
        arb_if.bus_ready = 1'b0;
        arb_if.bus_rvalid = 1'b1;
        arb_if.bus_rid = IW'(i);
        cyc();
        arb_if.bus_rvalid = 1'b0;
    endtask

    initial begin
        int pulses;
        int got;
        int exp_seq[4];
        idle_in();
        arb_if.m_addr = '0; arb_if.m_wdata = '0;
        arb_if.m_write = '0; arb_if.m_size = '0;
        cyc();
        check_en = 1'b1;
        cyc();
        #2;
        chk("rst_busy", arb_if.busy, 0);
        chk("rst_bus_valid", arb_if.bus_valid, 0);
        chk("rst_m_ready", arb_if.m_ready, 0);
        reset = 1'b0;
        cyc();

        // Priority, then held request with a slow bridge.
        set_req(2, 32'h0000_0040, 1'b1, 2'd2, 64'h55);
        serve(2);
        set_req(0, 32'h0000_0100, 1'b0, 2'd2, 64'h0);
        set_req(1, 32'h8000_0010, 1'b0, 2'd3, 64'h0);
        arb_if.m_valid = 3'b011;
        cyc();
        arb_if.bus_ready = 1'b1;
        #2;
        chk("t1_ready0", arb_if.m_ready, 3'b001);
        chk("t1_id0", arb_if.bus_id, 0);
        cyc();
        arb_if.m_valid = 3'b010;
        arb_if.bus_ready = 1'b0;
        arb_if.bus_rvalid = 1'b1;
        arb_if.bus_rid = 0;
        arb_if.bus_rdata = 64'hDEAD_BEEF_0000_0001;
        #2;
        chk("t1_rvalid0", arb_if.m_rvalid, 3'b001);
        chk("t1_rdata0", arb_if.m_rdata, 64'hDEAD_BEEF_0000_0001);
        cyc();
        arb_if.bus_rvalid = 1'b0;
        cyc();
        #2;
        chk("t1_id1", arb_if.bus_id, 1);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            chk("t2_valid", arb_if.bus_valid, 1);
            chk("t2_addr", arb_if.bus_addr, 32'h8000_0010);
            chk("t2_size", arb_if.bus_size, 3);
            if (arb_if.m_ready[1]) pulses++;
            cyc();
            #2;
        end
        arb_if.bus_ready = 1'b1;
        #1;
        if (arb_if.m_ready[1]) pulses++;
        cyc();
        arb_if.bus_ready = 1'b0;
        arb_if.m_valid = '0;
        #2;
        if (arb_if.m_ready[1]) pulses++;
        chk("t2_pulses", pulses, 1);

        // Flush while waiting drops the response.
        arb_if.m_flush = 3'b010;
        cyc();
        arb_if.m_flush = '0;
        arb_if.bus_rvalid = 1'b1;
        arb_if.bus_rid = 1;
        arb_if.bus_rdata = 64'h1111;
        #2;
        chk("t3_rvalid", arb_if.m_rvalid, 0);
        chk("t3_busy", arb_if.busy, 1);
        cyc();
        arb_if.bus_rvalid = 1'b0;
        #2;
        chk("t3_busy_fall", arb_if.busy, 0);

        // Response with a foreign ID is ignored.
        arb_if.m_valid = 3'b001;
        cyc();
        arb_if.bus_ready = 1'b1;
        arb_if.m_valid = '0;
        cyc();
        arb_if.bus_ready = 1'b0;
        arb_if.bus_rvalid = 1'b1;
        arb_if.bus_rid = 1;
        #2;
        chk("t4_wrong_id", arb_if.m_rvalid, 0);
        cyc();
        arb_if.bus_rid = 0;
        arb_if.bus_rdata = 64'h1234;
        #2;
        chk("t4_right_id", arb_if.m_rvalid, 3'b001);
        chk("t4_rdata", arb_if.m_rdata, 64'h1234);
        cyc();
        arb_if.bus_rvalid = 1'b0;

        // Grant sequence with everyone requesting.
        serve(2);
        if (RR) begin
            exp_seq[0] = 0; exp_seq[1] = 1;
            exp_seq[2] = 2; exp_seq[3] = 0;
        end else begin
            exp_seq[0] = 0; exp_seq[1] = 0;
            exp_seq[2] = 0; exp_seq[3] = 0;
        end
        arb_if.m_valid = 3'b111;
        for (int n = 0; n < 4; n++) begin
            cyc();
            #2;
            chk("t5_issue", arb_if.bus_valid, 1);
            got = int'(arb_if.bus_id);
            chk("t5_seq", got, exp_seq[n]);
            arb_if.bus_ready = 1'b1;
            cyc();
            arb_if.bus_ready = 1'b0;
            arb_if.bus_rvalid = 1'b1;
            arb_if.bus_rid = IW'(got);
            cyc();
            arb_if.bus_rvalid = 1'b0;
        end
        arb_if.m_valid = '0;
        cyc();

        // Reset in WAIT clears everything; late response ignored.
        arb_if.m_valid = 3'b001;
        cyc();
        arb_if.bus_ready = 1'b1;
        arb_if.m_valid = '0;
        cyc();
        arb_if.bus_ready = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #2;
        chk("t6_busy", arb_if.busy, 0);
        chk("t6_bus_valid", arb_if.bus_valid, 0);
        chk("t6_bus_addr", arb_if.bus_addr, 0);
        chk("t6_bus_id", arb_if.bus_id, 0);
        chk("t6_m_ready", arb_if.m_ready, 0);
        arb_if.bus_rvalid = 1'b1;
        arb_if.bus_rid = 0;
        arb_if.bus_rdata = 64'hABCD;
        #1;
        chk("t6_late_rvalid", arb_if.m_rvalid, 0);
        chk("t6_late_rdata", arb_if.m_rdata, 0);
        cyc();
        arb_if.bus_rvalid = 1'b0;

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            arb_if.m_valid = N'($urandom);
            for (int b = 0; b < N; b++)
                arb_if.m_flush[b] = ($urandom_range(0, 9) == 0);
            arb_if.m_write = N'($urandom);
            arb_if.m_size  = (2*N)'($urandom);
            for (int b = 0; b < N; b++) begin
                arb_if.m_addr[b*AW +: AW]  = $urandom;
                arb_if.m_wdata[b*DW +: DW] = {$urandom, $urandom};
            end
            arb_if.bus_ready  = $urandom_range(0, 1) != 0;
            arb_if.bus_rvalid = $urandom_range(0, 2) == 0;
            arb_if.bus_rid    = ($urandom_range(0, 7) == 0) ?
                                IW'($urandom) : IW'($urandom_range(0, N-1));
            arb_if.bus_rdata  = {$urandom, $urandom};
            cyc();
        end
        reset = 1'b0;
        idle_in();
        cyc();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
